// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and fetches from the boot ROM or from
// external instruction memory, presenting {instr, pc} to decode.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   rom_addr / rom_instr  boot ROM word address out, combinational data in
//   imem_req / imem_addr  external memory request, byte address
//   imem_ack / imem_rdata one-cycle acknowledge with data
//   redirect, redirect_pc load a new PC and flush
//   out_valid/out_ready   output handshake with decode
//   out_instr, out_pc     fetched instruction and its byte address
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          ROM_AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_instr,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc
);

    localparam logic [1:0] RUN         = 2'd0;
    localparam logic [1:0] MEM_WAIT    = 2'd1;
    localparam logic [1:0] MEM_HOLD    = 2'd2;
    localparam logic [1:0] MEM_DISCARD = 2'd3;

    logic [31:0] pc, pc_d;
    logic [1:0]  state, state_d;
    logic        valid_d;
    logic [31:0] instr_d, opc_d;
    logic        req_d;
    logic [31:0] addr_d;
    logic [31:0] hold_instr, hold_instr_d;
    logic [31:0] hold_pc, hold_pc_d;

    logic        in_rom;
    logic        can_load;
    logic [31:0] pc_inc;

    assign rom_addr = pc[ROM_AW+1:2];
    assign in_rom   = (pc[31:ROM_AW+2] == RESET_PC[31:ROM_AW+2]);
    assign can_load = !out_valid || out_ready;
    assign pc_inc   = pc + 32'd4;

    always_comb begin
        pc_d         = pc;
        state_d      = state;
        valid_d      = out_valid;
        instr_d      = out_instr;
        opc_d        = out_pc;
        req_d        = imem_req;
        addr_d       = imem_addr;
        hold_instr_d = hold_instr;
        hold_pc_d    = hold_pc;

        // Consumed entry with nothing new behind it.
        if (out_valid && out_ready)
            valid_d = 1'b0;

        if (redirect) begin
            pc_d    = redirect_pc & ~32'd3;
            valid_d = 1'b0;
            case (state)
                MEM_WAIT: begin
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        // Request stays outstanding; its data is dropped.
                        state_d = MEM_DISCARD;
                    end
                end
                MEM_DISCARD: begin
                    // An ack here still retires the dropped request.
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end else begin
            case (state)
                RUN: begin
                    if (in_rom) begin
                        if (can_load) begin
                            instr_d = rom_instr;
                            opc_d   = pc;
                            valid_d = 1'b1;
                            pc_d    = pc_inc;
                        end
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = pc;
                        state_d = MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (imem_ack) begin
                        pc_d  = pc_inc;
                        req_d = 1'b0;
                        if (can_load) begin
                            instr_d = imem_rdata;
                            opc_d   = imem_addr;
                            valid_d = 1'b1;
                            state_d = RUN;
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = imem_addr;
                            state_d      = MEM_HOLD;
                        end
                    end
                end
                MEM_HOLD: begin
                    if (can_load) begin
                        instr_d = hold_instr;
                        opc_d   = hold_pc;
                        valid_d = 1'b1;
                        state_d = RUN;
                    end
                end
                MEM_DISCARD: begin
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            state      <= RUN;
            out_valid  <= 1'b0;
            out_instr  <= 32'd0;
            out_pc     <= 32'd0;
            imem_req   <= 1'b0;
            imem_addr  <= 32'd0;
            hold_instr <= 32'd0;
            hold_pc    <= 32'd0;
        end else begin
            pc         <= pc_d;
            state      <= state_d;
            out_valid  <= valid_d;
            out_instr  <= instr_d;
            out_pc     <= opc_d;
            imem_req   <= req_d;
            imem_addr  <= addr_d;
            hold_instr <= hold_instr_d;
            hold_pc    <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch.
// Boot ROM modelled as 0x10000000 | word address.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [4:0]  rom_addr;
    logic [31:0] rom_instr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int errors = 0;
    int checks = 0;

    instr_fetch #(
        .RESET_PC(32'hBFC00000),
        .ROM_AW  (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rom_addr   (rom_addr),
        .rom_instr  (rom_instr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
    );

    assign rom_instr = 32'h10000000 | {27'd0, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag,
                           input logic [31:0] pc,
                           input logic [31:0] ins);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, out_instr, ins);
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        out_ready   = 1'b1;

        step();
        step();
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.pc", out_pc, 32'd0);
        chk("rst.instr", out_instr, 32'd0);
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.addr", imem_addr, 32'd0);
        chk("rst.rom_addr", {27'd0, rom_addr}, 32'd0);
        reset = 1'b0;

        // Boot ROM streaming, one per cycle.
        step();
        chk_out("rom0", 32'hBFC00000, 32'h10000000);
        chk("rom0.ra", {27'd0, rom_addr}, 32'd1);
        step();
        chk_out("rom1", 32'hBFC00004, 32'h10000001);
        step();
        chk_out("rom2", 32'hBFC00008, 32'h10000002);
        chk("rom2.ra", {27'd0, rom_addr}, 32'd3);

        // Backpressure: output and pc hold.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 32'hBFC00008, 32'h10000002);
            chk("stall.ra", {27'd0, rom_addr}, 32'd3);
        end
        out_ready = 1'b1;
        step();
        chk_out("rom3", 32'hBFC0000C, 32'h10000003);

        // Redirect to external memory; low bits masked.
        redirect    = 1'b1;
        redirect_pc = 32'h00400003;
        step();
        redirect = 1'b0;
        chk("rd.flush", {31'd0, out_valid}, 32'd0);
        chk("rd.req0", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mw.req", {31'd0, imem_req}, 32'd1);
            chk("mw.addr", imem_addr, 32'h00400000);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h12345678;
        step();
        imem_ack = 1'b0;
        chk_out("mem0", 32'h00400000, 32'h12345678);
        chk("mem0.req", {31'd0, imem_req}, 32'd0);
        step();
        chk("mem1.req", {31'd0, imem_req}, 32'd1);
        chk("mem1.addr", imem_addr, 32'h00400004);
        chk("mem1.drain", {31'd0, out_valid}, 32'd0);

        imem_ack   = 1'b1;
        imem_rdata = 32'h87654321;
        step();
        imem_ack = 1'b0;
        chk_out("mem1", 32'h00400004, 32'h87654321);

        // Ack while output is stalled goes into the hold register.
        out_ready = 1'b0;
        step();
        chk("hw.req", {31'd0, imem_req}, 32'd1);
        chk("hw.addr", imem_addr, 32'h00400008);
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hAAAA0001;
        step();
        imem_ack = 1'b0;
        chk("hold.req", {31'd0, imem_req}, 32'd0);
        chk_out("hold.old", 32'h00400004, 32'h87654321);
        step();
        chk("hold2.req", {31'd0, imem_req}, 32'd0);
        chk_out("hold2.old", 32'h00400004, 32'h87654321);
        out_ready = 1'b1;
        step();
        chk_out("hold.new", 32'h00400008, 32'hAAAA0001);
        step();
        chk("post.valid", {31'd0, out_valid}, 32'd0);
        chk("post.req", {31'd0, imem_req}, 32'd1);
        chk("post.addr", imem_addr, 32'h0040000C);

        // Redirect while waiting: request kept, data discarded.
        redirect    = 1'b1;
        redirect_pc = 32'hBFC00010;
        step();
        redirect = 1'b0;
        chk("disc.valid", {31'd0, out_valid}, 32'd0);
        chk("disc.req", {31'd0, imem_req}, 32'd1);
        chk("disc.addr", imem_addr, 32'h0040000C);
        step();
        chk("disc2.req", {31'd0, imem_req}, 32'd1);
        chk("disc.ra", {27'd0, rom_addr}, 32'd4);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step();
        imem_ack = 1'b0;
        chk("disc.ack.req", {31'd0, imem_req}, 32'd0);
        chk("disc.ack.valid", {31'd0, out_valid}, 32'd0);
        step();
        chk_out("disc.next", 32'hBFC00010, 32'h10000004);

        // Async reset in the middle of a memory wait.
        redirect    = 1'b1;
        redirect_pc = 32'h00400000;
        step();
        redirect = 1'b0;
        step();
        chk("ar.req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar.req0", {31'd0, imem_req}, 32'd0);
        chk("ar.valid0", {31'd0, out_valid}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk_out("ar.restart", 32'hBFC00000, 32'h10000000);

        // PC wraps modulo 2^32.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        step();
        redirect = 1'b0;
        step();
        chk("wrap.addr", imem_addr, 32'hFFFFFFFC);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BADF00D;
        step();
        imem_ack = 1'b0;
        chk_out("wrap.out", 32'hFFFFFFFC, 32'h0BADF00D);
        step();
        chk("wrap.req", {31'd0, imem_req}, 32'd1);
        chk("wrap.next", imem_addr, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
